// File: rtl/i2s_sample_buffer_pkg.sv
// Shared audio types for the I2S sample path: sample word and buffer state.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
`timescale 1ns/1ps
package audio_pkg;

  localparam int SAMPLE_W = 24;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  // FILL: accumulate until the threshold is met; STREAM: serve samples downstream.
  typedef enum logic {
    FILL   = 1'b0,
    STREAM = 1'b1
  } buf_state_e;

endpackage

// File: rtl/i2s_sample_buffer_if.sv
// Bundle of capture-side, consumer-side and status signals of the sample buffer.
// Latency: n/a (wiring only).
// Backpressure: read_valid_o/read_ready_i handshake; capture side cannot be stalled.
`timescale 1ns/1ps
interface i2s_sample_buffer_if
  import audio_pkg::*;
#(
  parameter int DATA_W = SAMPLE_W,
  parameter int DEPTH  = 256
);
  localparam int FW = $clog2(DEPTH) + 1;

  logic                     sample_valid_i;
  logic signed [DATA_W-1:0] left_sample_i;
  logic signed [DATA_W-1:0] right_sample_i;
  logic                     clear_i;
  logic signed [DATA_W-1:0] read_data_o;
  logic                     read_valid_o;
  logic                     read_ready_i;
  logic                     buffer_ready_o;
  logic                     overflow_o;
  logic [FW-1:0]            fill_o;

  // The buffer itself.
  modport slave (
    input  sample_valid_i, left_sample_i, right_sample_i, clear_i, read_ready_i,
    output read_data_o, read_valid_o, buffer_ready_o, overflow_o, fill_o
  );

  // Capture source plus consumer.
  modport master (
    output sample_valid_i, left_sample_i, right_sample_i, clear_i, read_ready_i,
    input  read_data_o, read_valid_o, buffer_ready_o, overflow_o, fill_o
  );

endinterface

// File: rtl/i2s_sample_buffer_ram.sv
// Simple-dual-port sample storage: one write port, one registered read port.
// Latency: read data appears one clock after re_i.
// Backpressure: none; the caller guarantees it never reads an unwritten slot.
`timescale 1ns/1ps
module sample_ram_sdp #(
  parameter int DEPTH  = 256,
  parameter int DATA_W = 24,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Storage array and read register; deliberately unreset so it maps to block RAM.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/i2s_sample_buffer.sv
// Channel-selecting sample FIFO from the I2S capture strobe to a ready/valid consumer.
// Latency: strobe in cycle N -> read_valid_o in N+3 when streaming from empty.
// Backpressure: output held while !read_ready_i; writes to a full buffer are dropped (sticky overflow).
`timescale 1ns/1ps
module i2s_sample_buffer
  import audio_pkg::*;
#(
  parameter int   DATA_W      = SAMPLE_W,
  parameter int   DEPTH       = 256,
  parameter int   THRESH      = 64,
  parameter logic SELECT_LEFT = 1'b1
) (
  input logic                 clk_i,
  input logic                 rst_i,
  i2s_sample_buffer_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;
  localparam logic [FW-1:0] FULL_LVL   = FW'(DEPTH);
  localparam logic [FW-1:0] THRESH_LVL = FW'(THRESH);

  buf_state_e        state_q;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [FW-1:0]     fill_q, fill_d;
  logic              pend_q, pend_d;
  logic              out_vld_q, out_vld_d;
  logic [DATA_W-1:0] out_dat_q, out_dat_d;
  logic              ovf_q, ovf_d;

  logic              flush;
  logic              wr_en;
  logic              accept;
  logic              fetch;
  logic [FW-1:0]     ram_cnt;
  logic [DATA_W-1:0] wr_dat;
  logic [DATA_W-1:0] ram_rdata;

  // Event decode: clear outranks everything, so it also gates RAM port activity.
  always_comb begin
    flush   = rst_i || bus.clear_i;
    wr_en   = bus.sample_valid_i && (fill_q != FULL_LVL) && !flush;
    accept  = out_vld_q && bus.read_ready_i;
    // fill covers RAM + in-flight fetch + output register; strip the last two.
    ram_cnt = fill_q - FW'(pend_q) - FW'(out_vld_q);
    fetch   = (state_q == STREAM) && (ram_cnt != '0) && !pend_q &&
              (!out_vld_q || accept) && !flush;
    wr_dat  = SELECT_LEFT ? bus.left_sample_i : bus.right_sample_i;
  end

  sample_ram_sdp #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_dat),
    .re_i    (fetch),
    .raddr_i (rd_ptr_q),
    .rdata_o (ram_rdata)
  );

  // Next-state for pointers, occupancy, fetch tracking, output register and overflow.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    fill_d    = fill_q + FW'(wr_en) - FW'(accept);
    pend_d    = fetch;
    out_vld_d = out_vld_q;
    out_dat_d = out_dat_q;
    ovf_d     = ovf_q || (bus.sample_valid_i && (fill_q == FULL_LVL));
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (fetch) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    // A returning fetch reloads the register even if the old word is accepted this edge.
    if (pend_q) begin
      out_vld_d = 1'b1;
      out_dat_d = ram_rdata;
    end else if (accept) begin
      out_vld_d = 1'b0;
    end
  end

  // Datapath registers; reset and clear share one flush path.
  always_ff @(posedge clk_i) begin
    if (flush) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      fill_q    <= '0;
      pend_q    <= 1'b0;
      out_vld_q <= 1'b0;
      out_dat_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      fill_q    <= fill_d;
      pend_q    <= pend_d;
      out_vld_q <= out_vld_d;
      out_dat_q <= out_dat_d;
      ovf_q     <= ovf_d;
    end
  end

  // Fill/stream control: start on the registered count, stop once the last sample is taken.
  always_ff @(posedge clk_i) begin
    if (flush) begin
      state_q <= FILL;
    end else begin
      case (state_q)
        FILL:    if (fill_q >= THRESH_LVL) state_q <= STREAM;
        STREAM:  if (accept && (fill_d == '0)) state_q <= FILL;
        default: state_q <= FILL;
      endcase
    end
  end

  assign bus.read_data_o    = out_dat_q;
  assign bus.read_valid_o   = out_vld_q;
  assign bus.buffer_ready_o = (state_q == STREAM);
  assign bus.overflow_o     = ovf_q;
  assign bus.fill_o         = fill_q;

endmodule

// File: tb/tb_i2s_sample_buffer.sv
`timescale 1ns/1ps
module tb_i2s_sample_buffer;

  localparam int DW    = 24;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  i2s_sample_buffer_if #(.DATA_W(DW), .DEPTH(DEPTH)) ia ();
  i2s_sample_buffer_if #(.DATA_W(DW), .DEPTH(DEPTH)) ib ();

  // Instance A: left channel, streaming threshold 4.
  i2s_sample_buffer #(.DATA_W(DW), .DEPTH(DEPTH), .THRESH(4), .SELECT_LEFT(1'b1)) dut_a (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (ia.slave)
  );

  // Instance B: right channel, threshold equal to depth.
  i2s_sample_buffer #(.DATA_W(DW), .DEPTH(DEPTH), .THRESH(DEPTH), .SELECT_LEFT(1'b0)) dut_b (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (ib.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] qa [$];
  logic [31:0] qb [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  // Scoreboard check just before each edge, then advance past the edge.
  task automatic tick();
    logic [31:0] e;
    @(negedge clk);
    if (ia.read_valid_o && ia.read_ready_i) begin
      e = (qa.size() != 0) ? qa.pop_front() : 32'hDEAD_BEEF;
      chk("a_rd_data", 32'(ia.read_data_o), e);
    end
    if (ib.read_valid_o && ib.read_ready_i) begin
      e = (qb.size() != 0) ? qb.pop_front() : 32'hDEAD_BEEF;
      chk("b_rd_data", 32'(ib.read_data_o), e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input bit use_b, input int l, input int r, input bit store);
    if (use_b) begin
      ib.sample_valid_i = 1'b1;
      ib.left_sample_i  = DW'(l);
      ib.right_sample_i = DW'(r);
      if (store) qb.push_back(r);
    end else begin
      ia.sample_valid_i = 1'b1;
      ia.left_sample_i  = DW'(l);
      ia.right_sample_i = DW'(r);
      if (store) qa.push_back(l);
    end
    tick();
    ia.sample_valid_i = 1'b0;
    ib.sample_valid_i = 1'b0;
  endtask

  task automatic drain(input bit use_b, input int budget);
    int n = 0;
    while (((use_b ? qb.size() : qa.size()) != 0) && n < budget) begin
      tick();
      n++;
    end
    chk(use_b ? "b_drain_left" : "a_drain_left", use_b ? qb.size() : qa.size(), 0);
  endtask

  task automatic wait_vld_a(input int budget);
    int n = 0;
    while (!ia.read_valid_o && n < budget) begin
      tick();
      n++;
    end
    chk("a_wait_vld", 32'(ia.read_valid_o), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    ia.sample_valid_i = 0; ia.left_sample_i = '0; ia.right_sample_i = '0;
    ia.clear_i = 0; ia.read_ready_i = 0;
    ib.sample_valid_i = 0; ib.left_sample_i = '0; ib.right_sample_i = '0;
    ib.clear_i = 0; ib.read_ready_i = 0;

    // Reset held with the strobe toggling: nothing may be captured.
    rst = 1'b1;
    ia.left_sample_i = DW'(5);
    for (int i = 0; i < 4; i++) begin
      ia.sample_valid_i = ~ia.sample_valid_i;
      ib.sample_valid_i = ia.sample_valid_i;
      tick();
    end
    chk("rst_a_vld",  32'(ia.read_valid_o), 0);
    chk("rst_a_data", 32'(ia.read_data_o), 0);
    chk("rst_a_brdy", 32'(ia.buffer_ready_o), 0);
    chk("rst_a_ovf",  32'(ia.overflow_o), 0);
    chk("rst_a_fill", 32'(ia.fill_o), 0);
    chk("rst_b_fill", 32'(ib.fill_o), 0);
    ia.sample_valid_i = 0; ib.sample_valid_i = 0;
    rst = 1'b0;
    tick();
    chk("post_rst_a_fill", 32'(ia.fill_o), 0);

    // Threshold start, ordered streaming, return to FILL.
    ia.read_ready_i = 1'b1;
    strobe(0, 1, 7, 1);
    chk("a_fill1", 32'(ia.fill_o), 1);
    strobe(0, -2, 7, 1);
    strobe(0, 3, 7, 1);
    strobe(0, -4, 7, 1);
    chk("a_fill4", 32'(ia.fill_o), 4);
    chk("a_brdy_at_fill4", 32'(ia.buffer_ready_o), 0);
    tick();
    chk("a_brdy_rise", 32'(ia.buffer_ready_o), 1);
    chk("a_fill4_hold", 32'(ia.fill_o), 4);
    drain(0, 40);
    chk("a_brdy_drop", 32'(ia.buffer_ready_o), 0);
    chk("a_fill_empty", 32'(ia.fill_o), 0);
    chk("a_vld_empty", 32'(ia.read_valid_o), 0);

    // Consumer stall: output and occupancy frozen.
    ia.read_ready_i = 1'b0;
    for (int k = 0; k < 4; k++) strobe(0, 10 + k, 0, 1);
    wait_vld_a(20);
    chk("a_stall_first", 32'(ia.read_data_o), 10);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("a_stall_vld", 32'(ia.read_valid_o), 1);
      chk("a_stall_data", 32'(ia.read_data_o), 10);
      chk("a_stall_fill", 32'(ia.fill_o), 4);
    end
    ia.read_ready_i = 1'b1;
    drain(0, 40);
    chk("a_stall_end_fill", 32'(ia.fill_o), 0);

    // Write and accept on the same edge at fill 5.
    ia.read_ready_i = 1'b0;
    for (int k = 0; k < 5; k++) strobe(0, 20 + k, 0, 1);
    wait_vld_a(20);
    chk("a_fill5", 32'(ia.fill_o), 5);
    ia.read_ready_i = 1'b1;
    strobe(0, 25, 0, 1);
    chk("a_fill_wr_acc", 32'(ia.fill_o), 5);
    drain(0, 40);
    chk("a_wa_end_fill", 32'(ia.fill_o), 0);

    // Pointer wrap: 3*DEPTH sequential values in bursts of DEPTH.
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < DEPTH; k++) strobe(0, 100 + DEPTH * r + k, 0, 1);
      drain(0, 60);
      chk("a_wrap_ovf", 32'(ia.overflow_o), 0);
      chk("a_wrap_fill", 32'(ia.fill_o), 0);
    end

    // Overflow, then clear with a simultaneous strobe.
    ia.read_ready_i = 1'b0;
    for (int k = 0; k < 8; k++) strobe(0, 200 + k, 0, 1);
    chk("a_full_ovf0", 32'(ia.overflow_o), 0);
    strobe(0, 208, 0, 0);
    chk("a_full_ovf1", 32'(ia.overflow_o), 1);
    chk("a_full_fill", 32'(ia.fill_o), DEPTH);
    wait_vld_a(20);
    chk("a_full_head", 32'(ia.read_data_o), 200);
    ia.clear_i = 1'b1;
    strobe(0, 99, 0, 0);
    ia.clear_i = 1'b0;
    qa.delete();
    chk("clr_vld",  32'(ia.read_valid_o), 0);
    chk("clr_data", 32'(ia.read_data_o), 0);
    chk("clr_brdy", 32'(ia.buffer_ready_o), 0);
    chk("clr_ovf",  32'(ia.overflow_o), 0);
    chk("clr_fill", 32'(ia.fill_o), 0);
    tick();
    tick();
    chk("clr_fill_hold", 32'(ia.fill_o), 0);
    ia.read_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) strobe(0, 300 + k, 0, 1);
    drain(0, 40);
    chk("clr_after_fill", 32'(ia.fill_o), 0);

    // Instance B: THRESH == DEPTH, right channel, 10 strobes with no reads.
    ib.read_ready_i = 1'b0;
    for (int k = 0; k < 10; k++) begin
      strobe(1, -(k + 1), 100 + k, k < 8);
      if (k == 7) begin
        chk("b_fill8", 32'(ib.fill_o), DEPTH);
        chk("b_ovf_at8", 32'(ib.overflow_o), 0);
        chk("b_brdy_at8", 32'(ib.buffer_ready_o), 0);
      end
    end
    chk("b_fill_full", 32'(ib.fill_o), DEPTH);
    chk("b_ovf", 32'(ib.overflow_o), 1);
    chk("b_brdy", 32'(ib.buffer_ready_o), 1);
    ib.read_ready_i = 1'b1;
    drain(1, 60);
    chk("b_end_fill", 32'(ib.fill_o), 0);
    tick();
    tick();
    tick();
    chk("b_no_extra", 32'(ib.read_valid_o), 0);
    chk("b_ovf_sticky", 32'(ib.overflow_o), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("b_ovf_rst", 32'(ib.overflow_o), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
